message_frame_drain: RTL and testbench
======================================

Name: message_frame_drain

Overview:
- Reader end of the message FIFO path. Pulls complete frames out of a message FIFO through its byte/latch read interface and re-emits them as a ready/valid byte stream toward the host UART/USB transmitter.
- Frame format: byte0 event id, byte1 free, bytes2-3 total frame length (big-endian, includes the 4 header bytes), then payload.
- The block uses the length field to find the frame end, then appends an optional XOR checksum byte.
- It detects malformed lengths and stalled frames.

Parameters:
- CHECKSUM_EN, 1, 1 = append XOR checksum byte after the last frame byte; 0 = no trailer.
- TIMEOUT_W, 10, width of the stall counter. A frame aborts after 2^TIMEOUT_W - 1 consecutive stalled cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge).
- in_data  in  8  byte currently at the FIFO tail (combinational from FIFO).
- in_frame_valid  in  1  FIFO holds at least one complete frame / byte at tail is readable.
- in_data_latch  out  1  one-cycle pulse; FIFO advances tail at the next edge.
- out_data  out  8  output byte register.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the byte when out_valid&&out_ready.
- out_first  out  1  qualifies out_data as byte0 of a frame.
- out_last  out  1  qualifies out_data as final byte (checksum if enabled, else last frame byte).
- err_len  out  1  one-cycle pulse: length field < 4.
- err_abort  out  1  one-cycle pulse: stall timeout abort.
- frames_sent  out  16  count of frames fully emitted; wraps at 0xFFFF->0.

Behaviour:
- Reset values:
  - All outputs 0: out_valid=0, in_data_latch=0, err_*=0, frames_sent=0.
  - State=IDLE; internal count, length and checksum registers = 0.
- Output register "free" = !out_valid || out_ready.
- Fetch: in_data_latch=1 in a cycle iff state is IDLE/HDR/BODY, a frame byte is still owed, in_frame_valid=1, and the output register is free.
  - In that same cycle in_data is loaded into out_data and out_valid is set at the edge.
  - Maximum throughput is one byte per cycle, back-to-back. There is no fetch latency beyond the output register (1 cycle in_data->out_data).
  - in_data_latch is combinational from registered state, in_frame_valid and out_ready.
- If the output register is held (out_valid=1, out_ready=0), out_data, out_first and out_last are stable and no fetch occurs.
- States:
  - IDLE: on fetch, load byte0 with out_first=1, checksum=byte0, idx=1 -> HDR.
  - HDR: fetch bytes 1..3; update checksum (XOR). Byte2 -> len[15:8], byte3 -> len[7:0]. After byte3:
    - len<4: pulse err_len, treat frame as ending at byte3 -> CSUM (or DONE if CHECKSUM_EN=0, with out_last on byte3).
    - len==4: same as len<4 but with no err_len.
    - else: remaining=len-4 -> BODY.
  - BODY: fetch while remaining>0; decrement; XOR into checksum. The last fetched byte sets out_last when CHECKSUM_EN=0, then -> DONE; otherwise -> CSUM.
  - CSUM: when the output register is free, load the checksum with out_last=1 and no in_data_latch -> DONE.
  - DONE: when the last byte is accepted (out_valid&&out_ready with out_last), frames_sent++ -> IDLE. IDLE may fetch the next frame's byte0 in the cycle after.
- Length arithmetic: 16-bit unsigned. Maximum frame is 65535 bytes plus checksum.
- Stall:
  - In HDR/BODY, each cycle with a byte owed, the output register free and in_frame_valid=0 increments stall_cnt; any fetch clears it.
  - At all-ones: pulse err_abort, drop out_valid (no out_last emitted), clear checksum -> IDLE. frames_sent is not incremented.
  - Backpressure (out_ready=0) never counts as a stall.
- Reset mid-frame: immediate return to IDLE; any partially emitted frame is discarded with no trailer.
- Simultaneous accept and fetch in the same cycle is legal and required for full rate.

Test Plan:
- Single 6-byte frame {0x11,0x00,0x00,0x06,0xAA,0x55}, out_ready=1:
  - Expect 7 output bytes on consecutive cycles, out_first on 0x11.
  - Checksum 0x11^0x06^0xAA^0x55=0xE8 with out_last.
  - 6 in_data_latch pulses; frames_sent=1.
- Same frame with CHECKSUM_EN=0 -> out_last on 0x55; 6 bytes total.
- Two back-to-back frames, out_ready toggling 1/0 every cycle:
  - Every byte held stable while out_ready=0; no latch while held.
  - Second frame's out_first arrives only after the first frame's out_last is accepted; frames_sent=2.
- Length field 0x0002 -> err_len pulse after byte3; frame is 4 bytes plus checksum; the next frame is parsed correctly.
- in_frame_valid forced low after byte4 of a length-10 frame, TIMEOUT_W=4:
  - err_abort after 15 stall cycles; no out_last emitted; frames_sent unchanged.
- rst=0 asserted mid-BODY -> next cycle out_valid=0, state IDLE, frames_sent=0. The next valid frame drains correctly.

Source files
------------

// File: rtl/message_frame_drain.sv
// Drains complete frames from a message FIFO (byte/latch read side) into a ready/valid
// byte stream. The length field finds the frame end, and an optional XOR checksum byte follows.
module message_frame_drain #(
  parameter bit CHECKSUM_EN = 1'b1,
  parameter int TIMEOUT_W   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_frame_valid,
  output logic        in_data_latch,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic        err_len,
  output logic        err_abort,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {IDLE, HDR, BODY, CSUM, DONE} state_t;

  // Abort fires on the stalled cycle that would take the counter to all-ones.
  localparam logic [TIMEOUT_W-1:0] STALL_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] STALL_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state_reg;
  logic [7:0]           data_reg;
  logic                 valid_reg;
  logic                 first_reg;
  logic                 last_reg;
  logic                 err_len_reg;
  logic                 err_abort_reg;
  logic [15:0]          frames_reg;
  logic [15:0]          remaining_reg;
  logic [7:0]           len_hi_reg;
  logic [7:0]           csum_reg;
  logic [1:0]           idx_reg;
  logic [TIMEOUT_W-1:0] stall_reg;

  logic        out_free;
  logic        byte_owed;
  logic        fetch;
  logic        stall;
  logic [15:0] hdr_len;

  assign out_free  = !valid_reg || out_ready;
  assign byte_owed = (state_reg == IDLE) || (state_reg == HDR) ||
                     ((state_reg == BODY) && (remaining_reg != 16'd0));
  // Gated by rst so a frame being discarded by reset does not also advance the FIFO.
  assign fetch     = rst && byte_owed && in_frame_valid && out_free;
  assign stall     = ((state_reg == HDR) || (state_reg == BODY)) && byte_owed &&
                     out_free && !in_frame_valid;
  assign hdr_len   = {len_hi_reg, in_data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      data_reg      <= 8'd0;
      valid_reg     <= 1'b0;
      first_reg     <= 1'b0;
      last_reg      <= 1'b0;
      err_len_reg   <= 1'b0;
      err_abort_reg <= 1'b0;
      frames_reg    <= 16'd0;
      remaining_reg <= 16'd0;
      len_hi_reg    <= 8'd0;
      csum_reg      <= 8'd0;
      idx_reg       <= 2'd0;
      stall_reg     <= '0;
    end else begin
      err_len_reg   <= 1'b0;
      err_abort_reg <= 1'b0;
      if (valid_reg && out_ready) begin
        valid_reg <= 1'b0;
      end
      if (fetch) begin
        data_reg  <= in_data;
        valid_reg <= 1'b1;
        first_reg <= (state_reg == IDLE);
        last_reg  <= 1'b0;
        stall_reg <= '0;
      end

      case (state_reg)
        IDLE: begin
          if (fetch) begin
            csum_reg  <= in_data;
            idx_reg   <= 2'd1;
            state_reg <= HDR;
          end
        end
        HDR: begin
          if (fetch) begin
            csum_reg <= csum_reg ^ in_data;
            idx_reg  <= idx_reg + 2'd1;
            if (idx_reg == 2'd2) begin
              len_hi_reg <= in_data;
            end
            if (idx_reg == 2'd3) begin
              // A length of 4 or less ends the frame at the header.
              if (hdr_len <= 16'd4) begin
                err_len_reg <= (hdr_len < 16'd4);
                if (CHECKSUM_EN) begin
                  state_reg <= CSUM;
                end else begin
                  last_reg  <= 1'b1;
                  state_reg <= DONE;
                end
              end else begin
                remaining_reg <= hdr_len - 16'd4;
                state_reg     <= BODY;
              end
            end
          end
        end
        BODY: begin
          if (fetch) begin
            csum_reg      <= csum_reg ^ in_data;
            remaining_reg <= remaining_reg - 16'd1;
            if (remaining_reg == 16'd1) begin
              if (CHECKSUM_EN) begin
                state_reg <= CSUM;
              end else begin
                last_reg  <= 1'b1;
                state_reg <= DONE;
              end
            end
          end
        end
        CSUM: begin
          if (out_free) begin
            data_reg  <= csum_reg;
            valid_reg <= 1'b1;
            first_reg <= 1'b0;
            last_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (valid_reg && out_ready && last_reg) begin
            frames_reg <= frames_reg + 16'd1;
            csum_reg   <= 8'd0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Stall only counts with the output register free, so backpressure never aborts.
      if (stall) begin
        if (stall_reg == STALL_LAST) begin
          err_abort_reg <= 1'b1;
          valid_reg     <= 1'b0;
          csum_reg      <= 8'd0;
          stall_reg     <= '0;
          remaining_reg <= 16'd0;
          state_reg     <= IDLE;
        end else begin
          stall_reg <= stall_reg + STALL_ONE;
        end
      end
    end
  end

  assign in_data_latch = fetch;
  assign out_data      = data_reg;
  assign out_valid     = valid_reg;
  assign out_first     = first_reg;
  assign out_last      = last_reg;
  assign err_len       = err_len_reg;
  assign err_abort     = err_abort_reg;
  assign frames_sent   = frames_reg;

endmodule

// File: tb/tb_message_frame_drain.sv
// Bench for message_frame_drain: one instance with checksum, one without, both fed
// by a shared FIFO model with a read pointer per instance.
module tb_message_frame_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        out_ready;
  logic        flush;
  logic [7:0]  in_data   [2];
  logic        in_fv     [2];
  logic        latch     [2];
  logic [7:0]  out_data  [2];
  logic        out_valid [2];
  logic        out_first [2];
  logic        out_last  [2];
  logic        err_len   [2];
  logic        err_abort [2];
  logic [15:0] frames    [2];

  message_frame_drain #(.CHECKSUM_EN(1'b1), .TIMEOUT_W(4)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_frame_valid(in_fv[0]),
    .in_data_latch(latch[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_first(out_first[0]), .out_last(out_last[0]),
    .err_len(err_len[0]), .err_abort(err_abort[0]), .frames_sent(frames[0])
  );

  message_frame_drain #(.CHECKSUM_EN(1'b0), .TIMEOUT_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_frame_valid(in_fv[1]),
    .in_data_latch(latch[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_first(out_first[1]), .out_last(out_last[1]),
    .err_len(err_len[1]), .err_abort(err_abort[1]), .frames_sent(frames[1])
  );

  // FIFO model: byte-level readable whenever the read pointer trails the write pointer.
  logic [7:0] mem [0:1023];
  int wr_ptr;
  int rd_ptr [2];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      in_data[k] = mem[rd_ptr[k][9:0]];
      in_fv[k]   = (rd_ptr[k] < wr_ptr);
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (flush)         rd_ptr[k] <= wr_ptr;
      else if (latch[k]) rd_ptr[k] <= rd_ptr[k] + 1;
    end
  end

  int errlen_cnt [2];
  int abort_cnt  [2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (err_len[k])   errlen_cnt[k] <= errlen_cnt[k] + 1;
      if (err_abort[k]) abort_cnt[k]  <= abort_cnt[k] + 1;
    end
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] fq [$];
  logic [9:0] exp0 [$];
  logic [9:0] exp1 [$];

  // Writes fq into the FIFO and appends expected {first,last,data} records for both instances.
  task automatic add_frame();
    logic [15:0] len;
    logic [7:0]  x;
    int          n;
    len = {fq[2], fq[3]};
    n   = (len < 16'd4) ? 4 : int'(len);
    x   = 8'h00;
    for (int i = 0; i < fq.size(); i++) begin
      mem[wr_ptr[9:0]] = fq[i];
      wr_ptr++;
    end
    for (int i = 0; i < n; i++) begin
      x ^= fq[i];
      exp0.push_back({(i == 0), 1'b0, fq[i]});
      exp1.push_back({(i == 0), (i == n - 1), fq[i]});
    end
    exp0.push_back({1'b0, 1'b1, x});
  endtask

  task automatic push_raw();
    for (int i = 0; i < fq.size(); i++) begin
      mem[wr_ptr[9:0]] = fq[i];
      wr_ptr++;
    end
  endtask

  // mode 0: out_ready held high; mode 1: out_ready toggles 0/1 every cycle.
  task automatic drain(input int mode, input int cycles);
    int         idx [2];
    logic       pv [2];
    logic       pf [2];
    logic       pl [2];
    logic [7:0] pd [2];
    logic       pr;
    logic [9:0] e;
    int         sz;
    idx = '{0, 0};
    pv  = '{1'b0, 1'b0};
    pr  = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      out_ready = (mode == 0) ? 1'b1 : c[0];
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (pv[k] && !pr) begin
          chk($sformatf("hold_dut%0d_c%0d", k, c),
              32'({out_valid[k], out_first[k], out_last[k], out_data[k]}),
              32'({1'b1, pf[k], pl[k], pd[k]}));
        end
        if (out_valid[k] && !out_ready) begin
          chk($sformatf("held_latch_dut%0d_c%0d", k, c), 32'(latch[k]), 32'd0);
        end
        if (out_valid[k] && out_ready) begin
          sz = (k == 0) ? exp0.size() : exp1.size();
          $display("dut%0d accept 0x%02h first=%0d last=%0d", k, out_data[k], out_first[k], out_last[k]);
          if (idx[k] >= sz) begin
            chk($sformatf("extra_byte_dut%0d", k), 32'(idx[k]), 32'(sz - 1));
          end else begin
            e = (k == 0) ? exp0[idx[k]] : exp1[idx[k]];
            chk($sformatf("byte%0d_dut%0d", idx[k], k),
                32'({out_first[k], out_last[k], out_data[k]}), 32'(e));
          end
          idx[k]++;
        end
        pv[k] = out_valid[k];
        pf[k] = out_first[k];
        pl[k] = out_last[k];
        pd[k] = out_data[k];
      end
      pr = out_ready;
      @(posedge clk); #1;
    end
    chk("count_dut0", 32'(idx[0]), 32'(exp0.size()));
    chk("count_dut1", 32'(idx[1]), 32'(exp1.size()));
    exp0.delete();
    exp1.delete();
  endtask

  typedef struct {
    logic        rdy;
    logic        v0;
    logic [7:0]  d0;
    logic        f0;
    logic        l0;
    logic        lat0;
    logic [15:0] fs0;
    logic        v1;
    logic [7:0]  d1;
    logic        l1;
    logic        lat1;
    logic [15:0] fs1;
  } vec_t;

  vec_t vt [9];

  initial begin
    int el0, el1, ab0, ab1;
    int last_lat [2];
    int ab_cyc   [2];
    logic saw_last [2];

    // Single 6-byte frame at full rate; checksum 0x11^0x06^0xAA^0x55 = 0xE8.
    vt[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0};
    vt[1] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 16'd0, 1'b1, 8'h11, 1'b0, 1'b1, 16'd0};
    vt[2] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 8'h00, 1'b0, 1'b1, 16'd0};
    vt[3] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 8'h00, 1'b0, 1'b1, 16'd0};
    vt[4] = '{1'b1, 1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 8'h06, 1'b0, 1'b1, 16'd0};
    vt[5] = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 8'hAA, 1'b0, 1'b1, 16'd0};
    vt[6] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 8'h55, 1'b1, 1'b0, 16'd0};
    vt[7] = '{1'b1, 1'b1, 8'hE8, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1};
    vt[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1};

    n_chk     = 0;
    n_fail    = 0;
    wr_ptr    = 0;
    flush     = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_outs_dut%0d", k),
          32'({out_valid[k], latch[k], err_len[k], err_abort[k], out_first[k], out_last[k]}), 32'd0);
      chk($sformatf("reset_frames_dut%0d", k), 32'(frames[k]), 32'd0);
    end
    @(posedge clk); #1;

    fq = '{8'h11, 8'h00, 8'h00, 8'h06, 8'hAA, 8'h55};
    add_frame();
    exp0.delete();
    exp1.delete();
    for (int r = 0; r < 9; r++) begin
      out_ready = vt[r].rdy;
      @(negedge clk);
      $display("row %0d dut0 v=%0d d=0x%02h dut1 v=%0d d=0x%02h", r, out_valid[0], out_data[0], out_valid[1], out_data[1]);
      chk($sformatf("t%0d_valid0", r), 32'(out_valid[0]), 32'(vt[r].v0));
      if (vt[r].v0) begin
        chk($sformatf("t%0d_data0", r), 32'({out_first[0], out_last[0], out_data[0]}),
            32'({vt[r].f0, vt[r].l0, vt[r].d0}));
      end
      chk($sformatf("t%0d_latch0", r), 32'(latch[0]), 32'(vt[r].lat0));
      chk($sformatf("t%0d_frames0", r), 32'(frames[0]), 32'(vt[r].fs0));
      chk($sformatf("t%0d_valid1", r), 32'(out_valid[1]), 32'(vt[r].v1));
      if (vt[r].v1) begin
        chk($sformatf("t%0d_data1", r), 32'({out_last[1], out_data[1]}), 32'({vt[r].l1, vt[r].d1}));
      end
      chk($sformatf("t%0d_latch1", r), 32'(latch[1]), 32'(vt[r].lat1));
      chk($sformatf("t%0d_frames1", r), 32'(frames[1]), 32'(vt[r].fs1));
      @(posedge clk); #1;
    end

    // Two back-to-back frames under toggling backpressure.
    fq = '{8'h21, 8'h00, 8'h00, 8'h05, 8'h33};
    add_frame();
    fq = '{8'h44, 8'h01, 8'h00, 8'h07, 8'h01, 8'h02, 8'h03};
    add_frame();
    drain(1, 60);
    chk("frames_bp_dut0", 32'(frames[0]), 32'd3);
    chk("frames_bp_dut1", 32'(frames[1]), 32'd3);
    chk("errlen_pre_dut0", 32'(errlen_cnt[0]), 32'd0);

    // Short length field, then a normal frame right behind it.
    el0 = errlen_cnt[0];
    el1 = errlen_cnt[1];
    fq = '{8'h55, 8'h00, 8'h00, 8'h02};
    add_frame();
    fq = '{8'h66, 8'h00, 8'h00, 8'h05, 8'h77};
    add_frame();
    drain(0, 30);
    chk("errlen_dut0", 32'(errlen_cnt[0] - el0), 32'd1);
    chk("errlen_dut1", 32'(errlen_cnt[1] - el1), 32'd1);
    chk("frames_len_dut0", 32'(frames[0]), 32'd5);
    chk("frames_len_dut1", 32'(frames[1]), 32'd5);

    // Length-10 frame whose bytes stop after byte4: abort on the 15th stalled cycle.
    ab0 = abort_cnt[0];
    ab1 = abort_cnt[1];
    fq = '{8'h77, 8'h00, 8'h00, 8'h0A, 8'h99};
    push_raw();
    out_ready   = 1'b1;
    last_lat    = '{-1, -1};
    ab_cyc      = '{-1, -1};
    saw_last    = '{1'b0, 1'b0};
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (latch[k]) last_lat[k] = c;
        if (err_abort[k] && ab_cyc[k] < 0) ab_cyc[k] = c;
        if (out_valid[k] && out_last[k]) saw_last[k] = 1'b1;
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      $display("dut%0d stall: last latch cycle %0d, abort cycle %0d", k, last_lat[k], ab_cyc[k]);
      chk($sformatf("abort_delay_dut%0d", k), 32'(ab_cyc[k] - last_lat[k]), 32'd16);
      chk($sformatf("abort_last_dut%0d", k), 32'(saw_last[k]), 32'd0);
      chk($sformatf("frames_abort_dut%0d", k), 32'(frames[k]), 32'd5);
    end
    chk("abort_cnt_dut0", 32'(abort_cnt[0] - ab0), 32'd1);
    chk("abort_cnt_dut1", 32'(abort_cnt[1] - ab1), 32'd1);

    // Reset while in BODY, then a fresh frame.
    fq = '{8'h88, 8'h00, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04};
    push_raw();
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst   = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("latch_in_rst_dut0", 32'(latch[0]), 32'd0);
    chk("latch_in_rst_dut1", 32'(latch[1]), 32'd0);
    @(posedge clk); #1;
    rst   = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("post_rst_valid_dut%0d", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("post_rst_frames_dut%0d", k), 32'(frames[k]), 32'd0);
    end
    @(posedge clk); #1;
    fq = '{8'h99, 8'h00, 8'h00, 8'h05, 8'h5A};
    add_frame();
    drain(0, 20);
    chk("frames_final_dut0", 32'(frames[0]), 32'd1);
    chk("frames_final_dut1", 32'(frames[1]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
